// File: rtl/sync_fifo_rd_stream.sv
// FWFT valid/ready adapter for a registered-read FIFO: 3-entry skid buffer, out_valid 2 cycles after fifo_rd, 1 word/cycle.
// fifo_rd is registered-state driven (no out_ready path); optional beat counter under SYNC_FIFO_RD_STREAM_STAT_EN.
module sync_fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      beat_cnt
);

  logic [1:0]       occ_q, occ_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic             infl_q, infl_d;
  logic [WIDTH-1:0] mem_q [3];
  logic [WIDTH-1:0] mem_d [3];
  logic             push;
  logic             pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A slot is held back for the word already in flight, so capture never overflows.
  assign fifo_rd   = rst_n & ~flush & ~fifo_empty &
                     (({1'b0, occ_q} + {2'b0, infl_q}) < 3'd3);
  assign out_valid = rst_n & (occ_q != 2'd0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign push      = infl_q & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    infl_d = infl_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[tail_q] = fifo_dout;
    end
    if (flush) begin
      occ_d  = 2'd0;
      infl_d = 1'b0;
      head_d = 2'd0;
      tail_d = 2'd0;
    end else begin
      infl_d = fifo_rd;
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= 2'd0;
      tail_q <= 2'd0;
      infl_q <= 1'b0;
      mem_q  <= '{default: '0};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      infl_q <= infl_d;
      mem_q  <= mem_d;
    end
  end

`ifdef SYNC_FIFO_RD_STREAM_STAT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Counts consumer handshakes, including one coinciding with flush; saturates.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= 32'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream: behavioural FIFO, word-order scoreboard, directed timing steps, random traffic.
module tb_sync_fifo_rd_stream;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          empty_force = 1'b0;
  logic          fempty_q = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          out_valid;
  logic [W-1:0]  fifo_dout = '0;
  logic [W-1:0]  out_data;
  logic [31:0]   beat_cnt;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [31:0] acc_cnt = 32'd0;
  logic [W-1:0] fq[$];
  logic [W-1:0] pend_q[$];
  logic [W-1:0] exp_q[$];
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  assign fifo_empty = fempty_q | empty_force;

  always #5 clk = ~clk;

  sync_fifo_rd_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_rd   (fifo_rd),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // FIFO with one-cycle registered read; words written via pend_q land one edge later.
  always @(posedge clk) begin : fifo_model
    logic [W-1:0] w;
    if (fifo_rd && fq.size() != 0) begin
      w = fq.pop_front();
      fifo_dout <= w;
    end
    while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
    fempty_q <= (fq.size() == 0);
  end

  // Scoreboard: exp_q holds words taken from the FIFO and not yet delivered or flushed.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
      acc_cnt = 32'd0;
    end else begin
      check("occ_bound", 32'(exp_q.size() <= 3), 32'd1);
      if (fifo_rd) check("rd_when_empty", 32'(fifo_empty), 32'd0);
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid) begin
        check("valid_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          delivered++;
          if (acc_cnt != 32'hFFFF_FFFF) acc_cnt = acc_cnt + 32'd1;
        end
      end
      prev_hold = out_valid & ~out_ready & ~flush;
      prev_data = out_data;
      if (flush) exp_q.delete();
      if (fifo_rd && fq.size() != 0) exp_q.push_back(fq[0]);
`ifndef SYNC_FIFO_RD_STREAM_STAT_EN
      check("beat_cnt_zero", beat_cnt, 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got[$];
    int n;
    int d0;
    int sent_n;

    // Reset with a non-empty FIFO
    for (int i = 0; i < 8; i++) pend_q.push_back(8'(8'h11 + i));
    repeat (3) begin
      @(negedge clk);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_beat", beat_cnt, 32'd0);
    end

    // Latency and full-rate stream
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("lat_rd_c0", 32'(fifo_rd), 32'd1);
    check("lat_valid_c0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_c1", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(8'h11 + i));
    end
    @(negedge clk);
    check("stream_end", 32'(out_valid), 32'd0);
`ifdef SYNC_FIFO_RD_STREAM_STAT_EN
    check("stat_after_stream", beat_cnt, 32'd8);
`endif

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pend_q.push_back(8'(8'h21 + i));
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (fifo_rd) n++;
    end
    check("bp_rd_pulses", 32'(n), 32'd3);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head", 32'(out_data), 32'h21);
    check("bp_rd_off", 32'(fifo_rd), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    got.delete();
    repeat (10) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
    end
    check("bp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check("bp_order", 32'(got[i]), 32'(8'h21 + i));
    end
`ifdef SYNC_FIFO_RD_STREAM_STAT_EN
    check("stat_after_bp", beat_cnt, 32'd13);
`endif

    // Flush with occ=2 and one word in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pend_q.push_back(8'(8'h31 + i));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_rd && n < 10);
    check("fl_first_rd", 32'(fifo_rd), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("fl_valid_before", 32'(out_valid), 32'd1);
    check("fl_rd_off", 32'(fifo_rd), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_cleared", 32'(out_valid), 32'd0);
    check("fl_rd_resume", 32'(fifo_rd), 32'd1);
    @(negedge clk);
    check("fl_gap", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("fl_resume_valid", 32'(out_valid), 32'd1);
    check("fl_resume_data", 32'(out_data), 32'h34);
    repeat (3) @(posedge clk);
    #1;

    // fifo_empty toggling every cycle, random consumer, sparse writes
    d0 = delivered;
    sent_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      empty_force = c[0];
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        pend_q.push_back(W'($urandom));
        sent_n++;
      end
    end
    @(posedge clk); #1;
    empty_force = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((delivered - d0) < sent_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tog_all_delivered", 32'(delivered - d0), 32'(sent_n));
    repeat (5) @(negedge clk);
    check("tog_no_dup", 32'(delivered - d0), 32'(sent_n));

    // Random traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      empty_force = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) pend_q.push_back(W'($urandom));
    end
    @(posedge clk); #1;
    flush = 1'b0;
    empty_force = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((fq.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("rand_drained", 32'(out_valid), 32'd0);
    check("rand_fifo_empty", 32'(fq.size()), 32'd0);

`ifdef SYNC_FIFO_RD_STREAM_STAT_EN
    check("stat_model", beat_cnt, acc_cnt);
    @(posedge clk); #1;
    dut.beat_cnt_q = 32'hFFFF_FFFD;
    acc_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) pend_q.push_back(8'(8'h51 + i));
    repeat (12) @(negedge clk);
    check("stat_saturate", beat_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("stat_not_flushed", beat_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
